lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit in the execute/memory boundary of the RV32I core, directly downstream of the ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Runs a valid/ready handshake with the data memory and returns sign- or zero-extended load data.
- Holds the core via busy until the access completes; flags misaligned or illegal accesses without touching memory.

Parameters:
WIDTH  32  datapath/address width; byte-lane logic fixed at 4 lanes, WIDTH must be 32

Ports:
clk        in   1      core clock, rising edge
reset      in   1      asynchronous, active-high reset
req_valid  in   1      access request from core (sampled only in IDLE)
req_we     in   1      1 = store, 0 = load
funct3     in   3      RV32I width/sign code
addr       in   WIDTH  effective address (ALU y)
wdata      in   WIDTH  store data (rs2)
busy       out  1      stall request to core
done       out  1      one-cycle pulse: access complete
fault      out  1      one-cycle pulse: misaligned/illegal, no memory access
rdata      out  WIDTH  extended load result, registered
mem_req    out  1      memory request valid
mem_we     out  1      memory write enable
mem_addr   out  WIDTH  word address ({addr[31:2],2'b00})
mem_be     out  4      byte enables
mem_wdata  out  WIDTH  lane-replicated store data
mem_ready  in   1      memory accepted/completed the request this cycle
mem_rdata  in   WIDTH  read word, valid when mem_ready=1 on a load

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, fault, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rdata = 0. Reset mid-access drops mem_req at once; no done or fault is produced.
- funct3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Every other code is illegal.
- Alignment: H requires addr[0]=0. W requires addr[1:0]=00. B is always aligned.
- States: IDLE, BUS, DONE, FAULT.
- IDLE, req_valid=1, illegal or misaligned: go to FAULT. No memory request is made.
- IDLE, req_valid=1, legal and aligned: latch we, funct3, addr[1:0], mem_addr, mem_be, mem_wdata; go to BUS.
- BUS: mem_req=1, with mem_we/addr/be/wdata held stable until mem_ready=1.
  - On mem_ready, load: capture the extended mem_rdata into rdata.
  - On mem_ready, any access: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: fault=1 for one cycle, then IDLE. rdata is unchanged.
- busy (combinational) = (IDLE & req_valid & legal & aligned) | BUS. busy is low in DONE and FAULT.
- Latency: with zero-wait memory (mem_ready high in the first BUS cycle), accept at cycle 0, BUS at cycle 1, done at cycle 2. Each wait cycle adds one.
- req_valid is ignored outside IDLE. mem_ready is ignored outside BUS. mem_req is 0 outside BUS.
- Byte enables:
  - SB/LB/LBU: 0001 << addr[1:0]
  - SH/LH/LHU: 0011 << addr[1:0]
  - W: 1111
- Store data: SB replicates wdata[7:0] x4. SH replicates wdata[15:0] x2. SW passes wdata through.
- Load extract: shift mem_rdata right by 8*addr[1:0], then:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word.
- rdata holds its value until the next load completes. Stores do not modify rdata.

Decomposition:
- Shared package (core-wide), holding:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - lsu state encoding (2 bits)
  - a byte-lane count constant of 4
- One combinational sub-module, lsu_align. It covers:
  - legality and alignment check
  - mem_be and store-data replication
  - load extract and extend
- lsu keeps the FSM and registers.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, mem_ready high first BUS cycle -> mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF, done at cycle 2, busy high cycles 0-1.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5; SH addr=0x102, wdata=0x1234 -> be=1100, mem_wdata=0x12341234.
- mem_rdata=0x80FF7F01: LB addr=0x1 -> rdata=0x0000007F; LB addr=0x2 -> 0xFFFFFFFF; LBU addr=0x3 -> 0x00000080; LH addr=0x2 -> 0xFFFF80FF; LHU addr=0x0 -> 0x00007F01.
- LW with mem_ready delayed 3 cycles -> mem_req and outputs stable throughout; done 1 cycle after mem_ready; req_valid toggled during BUS is ignored.
- LW addr=0x102, SH addr=0x101, funct3=011 -> fault pulse next cycle, mem_req never asserted, busy stays low, rdata unchanged.
- Reset asserted mid-BUS (asynchronously, between edges) -> mem_req=0 immediately, state IDLE, no done; next legal request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - core-wide load/store encodings shared by the LSU files
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int LANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUS   = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data memory request/response bus between the LSU and memory
interface lsu_if import lsu_pkg::*; #(parameter int WIDTH = 32);

   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [LANES-1:0] mem_be;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ready;
   logic [WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - legality/alignment check, byte lanes, store replication and load extension
module lsu_align import lsu_pkg::*; #(parameter int WIDTH = 32) (
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [1:0]       req_lo,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             req_ok,
   output logic [LANES-1:0] req_be,
   output logic [WIDTH-1:0] req_wdata_rep,
   input  logic [2:0]       ld_funct3,
   input  logic [1:0]       ld_lo,
   input  logic [WIDTH-1:0] ld_word,
   output logic [WIDTH-1:0] ld_data
);

   logic             legal;
   logic             aligned;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      legal         = 1'b0;
      aligned       = 1'b0;
      req_be        = '0;
      req_wdata_rep = req_wdata;
      case (req_funct3)
         F3_B, F3_BU: begin
            // unsigned variants exist only for loads
            legal         = (req_funct3 == F3_B) || !req_we;
            aligned       = 1'b1;
            req_be        = 4'b0001 << req_lo;
            req_wdata_rep = {4{req_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            legal         = (req_funct3 == F3_H) || !req_we;
            aligned       = !req_lo[0];
            req_be        = 4'b0011 << req_lo;
            req_wdata_rep = {2{req_wdata[15:0]}};
         end
         F3_W: begin
            legal   = 1'b1;
            aligned = (req_lo == 2'b00);
            req_be  = 4'b1111;
         end
         default: ;
      endcase
      req_ok = legal && aligned;
   end

   always_comb begin
      shifted = ld_word >> {ld_lo, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
         F3_BU:   ld_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
         F3_HU:   ld_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: request FSM, memory handshake and load result register
module lsu import lsu_pkg::*; #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [WIDTH-1:0] rdata,
   lsu_if.master            mem
);

   lsu_state_t       state_q, state_d;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [1:0]       lo_q;
   logic [WIDTH-1:0] addr_q;
   logic [LANES-1:0] be_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] rdata_q;

   logic             req_ok;
   logic [LANES-1:0] req_be;
   logic [WIDTH-1:0] req_wdata_rep;
   logic [WIDTH-1:0] ld_data;
   logic             accept;
   logic             capture;
   logic             mreq;

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .req_we        (req_we),
      .req_funct3    (funct3),
      .req_lo        (addr[1:0]),
      .req_wdata     (wdata),
      .req_ok        (req_ok),
      .req_be        (req_be),
      .req_wdata_rep (req_wdata_rep),
      .ld_funct3     (f3_q),
      .ld_lo         (lo_q),
      .ld_word       (mem.mem_rdata),
      .ld_data       (ld_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      fault   = 1'b0;
      mreq    = 1'b0;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_ok) begin
                  busy    = 1'b1;
                  accept  = 1'b1;
                  state_d = ST_BUS;
               end else begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_BUS: begin
            busy = 1'b1;
            mreq = 1'b1;
            if (mem.mem_ready) begin
               capture = !we_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            fault   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         lo_q    <= 2'b00;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= funct3;
            lo_q    <= addr[1:0];
            addr_q  <= {addr[WIDTH-1:2], 2'b00};
            be_q    <= req_be;
            wdata_q <= req_wdata_rep;
         end
         if (capture) rdata_q <= ld_data;
      end
   end

   // write enable is qualified by BUS so it can never outlive the request
   assign mem.mem_req   = mreq;
   assign mem.mem_we    = mreq && we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdata_q;
   assign rdata         = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed bench for lsu against a transaction-level model
module tb_lsu;
   import lsu_pkg::*;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        fault;
   logic [31:0] rdata;

   lsu_if #(.WIDTH(32)) mif ();

   lsu #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .fault     (fault),
      .rdata     (rdata),
      .mem       (mif.master)
   );

   int total = 0;
   int bad   = 0;

   logic        check_en;
   logic        e_busy, e_done, e_fault, e_mreq, e_mwe;
   logic [31:0] e_maddr, e_mwdata, e_rdata;
   logic [3:0]  e_mbe;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("busy",    32'(busy),        32'(e_busy));
         chk("done",    32'(done),        32'(e_done));
         chk("fault",   32'(fault),       32'(e_fault));
         chk("mem_req", 32'(mif.mem_req), 32'(e_mreq));
         chk("mem_we",  32'(mif.mem_we),  32'(e_mwe));
         chk("rdata",   rdata,            e_rdata);
         if (e_mreq) begin
            chk("mem_addr",  mif.mem_addr,      e_maddr);
            chk("mem_be",    32'(mif.mem_be),   32'(e_mbe));
            chk("mem_wdata", mif.mem_wdata,     e_mwdata);
         end
      end
   end

   function automatic int model_size(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic bit model_ok(input logic we, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return legal && ((a % model_size(f3)) == 0);
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lo);
      int n;
      n = model_size(f3);
      return 4'(((1 << n) - 1) << lo);
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
      case (model_size(f3))
         1:       return 32'(wd[7:0]) * 32'h01010101;
         2:       return 32'(wd[15:0]) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_ld(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] lo);
      logic [31:0] s;
      s = word >> (8 * lo);
      case (f3)
         3'd0:    return (s[7:0] >= 8'h80) ? 32'(s[7:0]) - 32'h100 : 32'(s[7:0]);
         3'd1:    return (s[15:0] >= 16'h8000) ? 32'(s[15:0]) - 32'h10000 : 32'(s[15:0]);
         3'd4:    return 32'(s[7:0]);
         3'd5:    return 32'(s[15:0]);
         default: return word;
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic garbage();
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      funct3    = 3'($urandom_range(0, 7));
      addr      = $urandom;
      wdata     = $urandom;
      mif.mem_ready = 1'($urandom_range(0, 1));
      mif.mem_rdata = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         garbage();
         req_valid = 1'b0;
         e_busy = 0; e_done = 0; e_fault = 0; e_mreq = 0; e_mwe = 0;
      end
   endtask

   // one complete request starting in IDLE, returning inside its DONE/FAULT cycle
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int waits);
      bit ok;
      ok = model_ok(we, f3, a);
      cyc();
      garbage();
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      e_busy = ok; e_done = 0; e_fault = 0; e_mreq = 0; e_mwe = 0;
      if (!ok) begin
         cyc();
         garbage();
         e_busy = 0; e_fault = 1;
         return;
      end
      e_maddr  = a & 32'hFFFF_FFFC;
      e_mbe    = model_be(f3, a[1:0]);
      e_mwdata = model_wd(f3, wd);
      for (int i = 0; i <= waits; i++) begin
         cyc();
         garbage();
         mif.mem_ready = (i == waits);
         if (i == waits) mif.mem_rdata = word;
         e_busy = 1; e_mreq = 1; e_mwe = we;
      end
      cyc();
      garbage();
      e_busy = 0; e_mreq = 0; e_mwe = 0; e_done = 1;
      if (!we) e_rdata = model_ld(word, f3, a[1:0]);
   endtask

   task automatic rand_xact();
      logic [2:0] f3;
      logic [2:0] legal_f3 [5];
      legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else                          f3 = 3'($urandom_range(0, 7));
      xact(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom, $urandom_range(0, 3));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      check_en = 1'b0;
      reset = 1'b1;
      req_valid = 0; req_we = 0; funct3 = 0; addr = 0; wdata = 0;
      mif.mem_ready = 0; mif.mem_rdata = 0;
      e_busy = 0; e_done = 0; e_fault = 0; e_mreq = 0; e_mwe = 0;
      e_maddr = 0; e_mbe = 0; e_mwdata = 0; e_rdata = 0;
      #3;
      chk("rst_busy",    32'(busy), 0);
      chk("rst_done",    32'(done), 0);
      chk("rst_fault",   32'(fault), 0);
      chk("rst_mem_req", 32'(mif.mem_req), 0);
      chk("rst_mem_we",  32'(mif.mem_we), 0);
      chk("rst_addr",    mif.mem_addr, 0);
      chk("rst_be",      32'(mif.mem_be), 0);
      chk("rst_wdata",   mif.mem_wdata, 0);
      chk("rst_rdata",   rdata, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_en = 1'b1;

      chk("pin_be_sb",  32'(model_be(3'd0, 2'd3)), 32'h8);
      chk("pin_wd_sb",  model_wd(3'd0, 32'h000000A5), 32'hA5A5A5A5);
      chk("pin_be_sh",  32'(model_be(3'd1, 2'd2)), 32'hC);
      chk("pin_wd_sh",  model_wd(3'd1, 32'h00001234), 32'h12341234);
      chk("pin_be_sw",  32'(model_be(3'd2, 2'd0)), 32'hF);

      idle(2);
      xact(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      idle(1);
      xact(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0);
      xact(1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 1);
      xact(1'b0, 3'd0, 32'h1, 32'h0, 32'h80FF7F01, 0);
      chk("lit_lb1", rdata, 32'h0000007F);
      xact(1'b0, 3'd0, 32'h2, 32'h0, 32'h80FF7F01, 0);
      chk("lit_lb2", rdata, 32'hFFFFFFFF);
      xact(1'b0, 3'd4, 32'h3, 32'h0, 32'h80FF7F01, 0);
      chk("lit_lbu3", rdata, 32'h00000080);
      xact(1'b0, 3'd1, 32'h2, 32'h0, 32'h80FF7F01, 0);
      chk("lit_lh2", rdata, 32'hFFFF80FF);
      xact(1'b0, 3'd5, 32'h0, 32'h0, 32'h80FF7F01, 0);
      chk("lit_lhu0", rdata, 32'h00007F01);
      xact(1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 3);
      chk("lit_lw_wait", rdata, 32'hCAFEF00D);
      xact(1'b1, 3'd0, 32'h204, 32'h11223344, 32'h0, 0);
      chk("lit_store_keeps_rdata", rdata, 32'hCAFEF00D);
      xact(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
      xact(1'b1, 3'd1, 32'h101, 32'h0, 32'h0, 0);
      xact(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
      xact(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0);
      chk("lit_fault_keeps_rdata", rdata, 32'hCAFEF00D);

      // asynchronous reset in the middle of a BUS cycle
      idle(1);
      cyc();
      garbage();
      req_valid = 1; req_we = 0; funct3 = 3'd2; addr = 32'h300;
      e_busy = 1; e_mreq = 0; e_mwe = 0; e_done = 0; e_fault = 0;
      cyc();
      garbage();
      req_valid = 0; mif.mem_ready = 0;
      #1;
      chk("bus_before_reset", 32'(mif.mem_req), 1);
      check_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("reset_mem_req", 32'(mif.mem_req), 0);
      chk("reset_busy",    32'(busy), 0);
      chk("reset_done",    32'(done), 0);
      chk("reset_rdata",   rdata, 0);
      cyc();
      reset = 1'b0;
      e_busy = 0; e_mreq = 0; e_mwe = 0; e_done = 0; e_fault = 0; e_rdata = 0;
      req_valid = 0;
      check_en = 1'b1;
      idle(3);
      xact(1'b0, 3'd2, 32'h300, 32'h0, 32'h13579BDF, 1);
      chk("lit_after_reset", rdata, 32'h13579BDF);

      for (int n = 0; n < 400; n++) begin
         idle($urandom_range(0, 2));
         rand_xact();
      end
      idle(2);
      check_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
